// File: rtl/lc3_fetch_queue.sv
`default_nettype none
// ============================================================================
// lc3_fetch_queue : LC3 fetch stage with PC, req/ack memory port and queue
// Revision 1.0 : initial release
// ============================================================================
module lc3_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_fetch,
    input  logic        enable_updatePC,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        decode_ready,
    output logic        enable_decode,
    output logic [15:0] dout,
    output logic [15:0] npc_out,
    output logic [15:0] pc
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t C_DEPTH = cnt_t'(DEPTH);

    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic        r_req;
    logic        r_squash;
    ptr_t        r_head;
    ptr_t        r_tail;
    cnt_t        r_count;
    logic [15:0] r_data [DEPTH];
    logic [15:0] r_npc  [DEPTH];

    logic        w_redirect;
    logic        w_xfer;
    logic        w_hold;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_addr_inc;
    cnt_t        w_count_next;
    logic [15:0] w_pc_next;
    logic [15:0] w_addr_next;
    logic        w_req_next;
    logic        w_squash_next;

    assign w_redirect = enable_updatePC & br_taken;
    assign w_xfer     = r_req & imem_ack;
    assign w_hold     = r_req & ~imem_ack;
    // A squashed ack, or one coinciding with a redirect, belongs to the old path.
    assign w_push     = w_xfer & ~r_squash & ~w_redirect;
    assign w_pop      = enable_decode & decode_ready & ~w_redirect;
    assign w_addr_inc = r_addr + 16'd1;

    always_comb begin
        w_count_next  = r_count;
        w_pc_next     = r_pc;
        w_addr_next   = r_addr;
        w_req_next    = 1'b0;
        w_squash_next = 1'b0;

        if (w_redirect) begin
            w_count_next = '0;
            w_pc_next    = taddr;
        end else begin
            w_count_next = r_count + cnt_t'(w_push) - cnt_t'(w_pop);
            if (w_push) begin
                w_pc_next = w_addr_inc;
            end
        end

        // Only one read can be outstanding, so the credit check reduces to
        // room for one more entry once this edge's push/pop have settled.
        if (w_hold) begin
            w_req_next    = 1'b1;
            w_addr_next   = r_addr;
            w_squash_next = r_squash | w_redirect;
        end else begin
            w_req_next  = enable_fetch & (w_count_next < C_DEPTH);
            w_addr_next = w_pc_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_req    <= 1'b0;
            r_squash <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            r_pc     <= w_pc_next;
            r_addr   <= w_addr_next;
            r_req    <= w_req_next;
            r_squash <= w_squash_next;
            r_count  <= w_count_next;
            if (w_redirect) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + ptr_t'(1);
                if (w_pop)  r_head <= r_head + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_tail] <= imem_data;
            r_npc[r_tail]  <= w_addr_inc;
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_addr;
    assign pc            = r_pc;
    assign enable_decode = (r_count != '0);
    assign dout          = enable_decode ? r_data[r_head] : 16'h0000;
    assign npc_out       = enable_decode ? r_npc[r_head]  : 16'h0000;

    a_addr_stable: assert property (@(posedge clock) disable iff (!reset)
        (imem_req && !imem_ack) |=> $stable(imem_addr));
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_push && (r_count == C_DEPTH)));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_pop && (r_count == '0)));

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_lc3_fetch_queue : directed vector bench for the LC3 fetch queue
// Revision 1.0 : initial release
// ============================================================================
module tb_lc3_fetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_fetch = 1'b0;
    logic        enable_updatePC = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        decode_ready = 1'b0;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_out;
    logic [15:0] pc;

    int  lat = 0;
    int  wcnt = 0;
    bit  force_ack = 1'b0;
    int  tests = 0;
    int  fails = 0;
    int  row = 0;

    lc3_fetch_queue dut (
        .clock          (clock),
        .reset          (reset),
        .enable_fetch   (enable_fetch),
        .enable_updatePC(enable_updatePC),
        .br_taken       (br_taken),
        .taddr          (taddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_data      (imem_data),
        .decode_ready   (decode_ready),
        .enable_decode  (enable_decode),
        .dout           (dout),
        .npc_out        (npc_out),
        .pc             (pc)
    );

    always #5 clock = ~clock;

    // Memory image: four fixed words, everything else reads address + 0x1000.
    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h3000: mem = 16'h1111;
            16'h3001: mem = 16'h2222;
            16'h3002: mem = 16'h3333;
            16'h3003: mem = 16'h4444;
            default:  mem = a + 16'h1000;
        endcase
    endfunction

    // Ack arrives after lat wait cycles of a continuously held request.
    always @(posedge clock or negedge reset) begin
        if (!reset)                    wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                           wcnt <= 0;
    end
    assign imem_ack  = force_ack | (imem_req && (wcnt >= lat));
    assign imem_data = mem(imem_addr);

    typedef struct {
        bit          rst;
        int          lat;
        bit          ef, dr, upd, br;
        logic [15:0] ta;
        logic        req;
        logic [15:0] addr;
        logic        en;
        logic [15:0] d, n, p;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input int l, input bit ef, input bit dr,
                       input bit upd, input bit br, input logic [15:0] ta,
                       input logic req, input logic [15:0] addr, input logic en,
                       input logic [15:0] d, input logic [15:0] n, input logic [15:0] p);
        vec_t v;
        v.rst = rst; v.lat = l; v.ef = ef; v.dr = dr; v.upd = upd; v.br = br; v.ta = ta;
        v.req = req; v.addr = addr; v.en = en; v.d = d; v.n = n; v.p = p;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    task automatic do_reset(input int l);
        reset = 1'b0;
        enable_fetch = 1'b0; decode_ready = 1'b0;
        enable_updatePC = 1'b0; br_taken = 1'b0; taddr = 16'h0000;
        force_ack = 1'b0;
        lat = l;
        @(posedge clock);
        @(negedge clock);
        chk("rst_req",  {15'd0, imem_req}, 16'h0000);
        chk("rst_addr", imem_addr, 16'h3000);
        chk("rst_pc",   pc, 16'h3000);
        chk("rst_en",   {15'd0, enable_decode}, 16'h0000);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_npc",  npc_out, 16'h0000);
        reset = 1'b1;
    endtask

    initial begin
        // Zero-wait streaming
        add(1,0, 1,1,0,0,16'h0, 0,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3001, 1,16'h1111,16'h3001,16'h3001);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3002, 1,16'h2222,16'h3002,16'h3002);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3003, 1,16'h3333,16'h3003,16'h3003);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3004, 1,16'h4444,16'h3004,16'h3004);
        // Decode backpressure fills the queue, then drains
        add(1,0, 1,0,0,0,16'h0, 0,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,0, 1,0,0,0,16'h0, 1,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,0, 1,0,0,0,16'h0, 1,16'h3001, 1,16'h1111,16'h3001,16'h3001);
        add(0,0, 1,0,0,0,16'h0, 0,16'h3002, 1,16'h1111,16'h3001,16'h3002);
        add(0,0, 1,1,0,0,16'h0, 0,16'h3002, 1,16'h1111,16'h3001,16'h3002);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3002, 1,16'h2222,16'h3002,16'h3002);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3003, 1,16'h3333,16'h3003,16'h3003);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3004, 1,16'h4444,16'h3004,16'h3004);
        // Three-cycle memory, then redirect with a read in flight
        add(1,2, 1,1,0,0,16'h0, 0,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,2, 1,1,0,0,16'h0, 1,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,2, 1,1,0,0,16'h0, 1,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,2, 1,1,0,0,16'h0, 1,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,2, 1,1,0,0,16'h0, 1,16'h3001, 1,16'h1111,16'h3001,16'h3001);
        add(0,2, 1,1,0,0,16'h0, 1,16'h3001, 0,16'h0000,16'h0000,16'h3001);
        add(0,2, 1,1,0,0,16'h0, 1,16'h3001, 0,16'h0000,16'h0000,16'h3001);
        add(0,2, 1,0,1,1,16'h4000, 1,16'h3002, 1,16'h2222,16'h3002,16'h3002);
        add(0,2, 1,0,0,0,16'h0, 1,16'h3002, 0,16'h0000,16'h0000,16'h4000);
        add(0,2, 1,0,0,0,16'h0, 1,16'h3002, 0,16'h0000,16'h0000,16'h4000);
        add(0,2, 1,0,0,0,16'h0, 1,16'h4000, 0,16'h0000,16'h0000,16'h4000);
        add(0,2, 1,0,0,0,16'h0, 1,16'h4000, 0,16'h0000,16'h0000,16'h4000);
        add(0,2, 1,0,0,0,16'h0, 1,16'h4000, 0,16'h0000,16'h0000,16'h4000);
        add(0,2, 1,1,0,0,16'h0, 1,16'h4001, 1,16'h5000,16'h4001,16'h4001);
        // Unqualified branch, redirect coinciding with an ack, fetch disable
        add(1,0, 1,1,0,0,16'h0, 0,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,0, 1,1,0,0,16'h0, 1,16'h3000, 0,16'h0000,16'h0000,16'h3000);
        add(0,0, 1,1,0,1,16'h4000, 1,16'h3001, 1,16'h1111,16'h3001,16'h3001);
        add(0,0, 1,1,0,1,16'h4000, 1,16'h3002, 1,16'h2222,16'h3002,16'h3002);
        add(0,0, 1,1,1,1,16'h4000, 1,16'h3003, 1,16'h3333,16'h3003,16'h3003);
        add(0,0, 1,1,0,0,16'h0, 1,16'h4000, 0,16'h0000,16'h0000,16'h4000);
        add(0,0, 0,1,0,0,16'h0, 1,16'h4001, 1,16'h5000,16'h4001,16'h4001);
        add(0,0, 0,1,0,0,16'h0, 0,16'h4002, 1,16'h5001,16'h4002,16'h4002);
        add(0,0, 1,1,0,0,16'h0, 0,16'h4002, 0,16'h0000,16'h0000,16'h4002);
        add(0,0, 1,1,0,0,16'h0, 1,16'h4002, 0,16'h0000,16'h0000,16'h4002);

        foreach (vecs[i]) begin
            row = i;
            if (vecs[i].rst) do_reset(vecs[i].lat);
            lat             = vecs[i].lat;
            enable_fetch    = vecs[i].ef;
            decode_ready    = vecs[i].dr;
            enable_updatePC = vecs[i].upd;
            br_taken        = vecs[i].br;
            taddr           = vecs[i].ta;
            #1;
            chk("req",  {15'd0, imem_req}, {15'd0, vecs[i].req});
            chk("addr", imem_addr, vecs[i].addr);
            chk("en",   {15'd0, enable_decode}, {15'd0, vecs[i].en});
            chk("dout", dout, vecs[i].d);
            chk("npc",  npc_out, vecs[i].n);
            chk("pc",   pc, vecs[i].p);
            @(negedge clock);
        end

        // PC wrap at 16'hFFFF, then asynchronous reset in the middle of a request
        row = 1000;
        do_reset(0);
        enable_fetch = 1'b1; decode_ready = 1'b0;
        enable_updatePC = 1'b1; br_taken = 1'b1; taddr = 16'hFFFF;
        @(negedge clock);
        enable_updatePC = 1'b0; br_taken = 1'b0;
        #1;
        chk("wrap_req",  {15'd0, imem_req}, 16'h0001);
        chk("wrap_addr", imem_addr, 16'hFFFF);
        chk("wrap_pc",   pc, 16'hFFFF);
        @(negedge clock);
        #1;
        chk("wrap_en",   {15'd0, enable_decode}, 16'h0001);
        chk("wrap_dout", dout, 16'h0FFF);
        chk("wrap_npc",  npc_out, 16'h0000);
        chk("wrap_next", imem_addr, 16'h0000);
        chk("wrap_req2", {15'd0, imem_req}, 16'h0001);
        #1;
        reset = 1'b0;
        #1;
        chk("async_req",  {15'd0, imem_req}, 16'h0000);
        chk("async_pc",   pc, 16'h3000);
        chk("async_addr", imem_addr, 16'h3000);
        chk("async_en",   {15'd0, enable_decode}, 16'h0000);
        enable_fetch = 1'b0;
        force_ack = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("stray_ack_req", {15'd0, imem_req}, 16'h0000);
        chk("stray_ack_en",  {15'd0, enable_decode}, 16'h0000);
        chk("stray_ack_pc",  pc, 16'h3000);
        force_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
